alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/CPU_package.sv | 24 ++
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/CPU_package.sv
// Shared CPU datapath types: ALU opcode encoding, ALU flag bundle, datapath width.
package CPU_package;

   localparam int DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      ALU_OP_ADD = 3'd0,
      ALU_OP_SUB = 3'd1,
      ALU_OP_MUL = 3'd2,
      ALU_OP_DIV = 3'd3,
      ALU_OP_CPR = 3'd4,
      ALU_OP_AND = 3'd5,
      ALU_OP_OR  = 3'd6,
      ALU_OP_XOR = 3'd7
   } enum_alu_opcode_t;

   typedef struct packed {
      logic carry;
      logic zero;
      logic negative;
      logic overflow;
   } struct_alu_flag_t;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU. One operation in flight at a time;
// operands are latched at accept, the ALU result is captured after the op's occupancy,
// and the response is held until the consumer takes it.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; req_ready offered to the granted requester
// EXEC  | operands presented to the ALU; counter runs down the occupancy
// RESP  | result captured; rsp_valid held until rsp_ready
module alu_arbiter
   import CPU_package::*;
#(
   parameter int DATA_WIDTH = CPU_package::DATA_WIDTH,
   parameter int MC_CYCLES  = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic             [1:0]              req_valid,
   output logic             [1:0]              req_ready,
   input  logic             [1:0][DATA_WIDTH-1:0] req_a,
   input  logic             [1:0][DATA_WIDTH-1:0] req_b,
   input  enum_alu_opcode_t [1:0]              req_opcode,
   input  logic             [1:0]              req_mode,
   input  logic             [1:0]              req_carry,
   output logic             [DATA_WIDTH-1:0]   alu_in_a,
   output logic             [DATA_WIDTH-1:0]   alu_in_b,
   output logic                                alu_input_carry,
   output logic                                alu_mode,
   output enum_alu_opcode_t                    alu_opcode,
   input  logic             [DATA_WIDTH-1:0]   alu_out,
   input  struct_alu_flag_t                    alu_out_flag,
   output logic                                rsp_valid,
   output logic                                rsp_id,
   output logic             [DATA_WIDTH-1:0]   rsp_data,
   output struct_alu_flag_t                    rsp_flag,
   input  logic                                rsp_ready,
   output logic                                busy
);

   // 4 bits covers the legal MC_CYCLES range of 1..15
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic             last_grant;
   logic [CNT_W-1:0] cnt;
   logic             gnt_id;
   logic             gnt_mc;

   // Pick the winner: the lone requester, or on a tie the one not served last
   always_comb begin
      gnt_id = 1'b0;
      if (req_valid == 2'b11) begin
         gnt_id = ~last_grant;
      end else begin
         gnt_id = req_valid[1];
      end
   end

   // Multi-cycle only for MUL/DIV in mode 0; everything else completes in one EXEC cycle
   always_comb begin
      gnt_mc = 1'b0;
      if (((req_opcode[gnt_id] == ALU_OP_MUL) || (req_opcode[gnt_id] == ALU_OP_DIV))
          && !req_mode[gnt_id]) begin
         gnt_mc = 1'b1;
      end
   end

   // Accept is offered only while idle, and only to the granted requester
   always_comb begin
      req_ready = 2'b00;
      if ((state == IDLE) && (req_valid != 2'b00)) begin
         req_ready[gnt_id] = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   // Sequencer: latch operands at accept, count occupancy, capture and hold the result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         last_grant      <= 1'b1;
         cnt             <= '0;
         alu_in_a        <= '0;
         alu_in_b        <= '0;
         alu_input_carry <= 1'b0;
         alu_mode        <= 1'b0;
         alu_opcode      <= enum_alu_opcode_t'(3'd0);
         rsp_valid       <= 1'b0;
         rsp_id          <= 1'b0;
         rsp_data        <= '0;
         rsp_flag        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid != 2'b00) begin
                  alu_in_a        <= req_a[gnt_id];
                  alu_in_b        <= req_b[gnt_id];
                  alu_opcode      <= req_opcode[gnt_id];
                  alu_mode        <= req_mode[gnt_id];
                  alu_input_carry <= req_carry[gnt_id];
                  rsp_id          <= gnt_id;
                  cnt             <= gnt_mc ? MC_LOAD : '0;
                  state           <= EXEC;
               end
            end
            EXEC: begin
               if (cnt != '0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  rsp_data  <= alu_out;
                  rsp_flag  <= alu_out_flag;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               // Returning to IDLE first keeps a new accept out of the handshake cycle
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  last_grant <= rsp_id;
                  state      <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU stands in for the real one, and each
// transaction's grant, latency, response and hold behaviour is predicted from the
// request fields and the arbitration rules.
module tb_alu_arbiter;
   import CPU_package::*;

   localparam int W  = 16;
   localparam int MC = 4;

   logic                          clk;
   logic                          rst_n;
   logic             [1:0]        req_valid;
   logic             [1:0]        req_ready;
   logic             [1:0][W-1:0] req_a;
   logic             [1:0][W-1:0] req_b;
   enum_alu_opcode_t [1:0]        req_opcode;
   logic             [1:0]        req_mode;
   logic             [1:0]        req_carry;
   logic             [W-1:0]      alu_in_a;
   logic             [W-1:0]      alu_in_b;
   logic                          alu_input_carry;
   logic                          alu_mode;
   enum_alu_opcode_t              alu_opcode;
   logic             [W-1:0]      alu_out;
   struct_alu_flag_t              alu_out_flag;
   logic                          rsp_valid;
   logic                          rsp_id;
   logic             [W-1:0]      rsp_data;
   struct_alu_flag_t              rsp_flag;
   logic                          rsp_ready;
   logic                          busy;

   int   checks = 0;
   int   errors = 0;
   logic mdl_last;

   alu_arbiter #(.DATA_WIDTH(W), .MC_CYCLES(MC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
      .req_mode(req_mode), .req_carry(req_carry),
      .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
      .alu_input_carry(alu_input_carry), .alu_mode(alu_mode), .alu_opcode(alu_opcode),
      .alu_out(alu_out), .alu_out_flag(alu_out_flag),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_ref(enum_alu_opcode_t op, logic [W-1:0] a,
                                            logic [W-1:0] b, logic c);
      case (op)
         ALU_OP_ADD: return a + b + W'(c);
         ALU_OP_SUB: return a - b;
         ALU_OP_MUL: return W'(a * b);
         ALU_OP_DIV: return (b == '0) ? '1 : a / b;
         ALU_OP_CPR: return (a > b) ? W'(1) : ((a == b) ? W'(0) : '1);
         ALU_OP_AND: return a & b;
         ALU_OP_OR:  return a | b;
         default:    return a ^ b;
      endcase
   endfunction

   function automatic struct_alu_flag_t flag_ref(enum_alu_opcode_t op, logic [W-1:0] a,
                                                 logic [W-1:0] b, logic c);
      struct_alu_flag_t f;
      logic [W:0]       s;
      logic [W-1:0]     r;
      r          = alu_ref(op, a, b, c);
      s          = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      f.carry    = (op == ALU_OP_ADD) ? s[W] : 1'b0;
      f.zero     = (r == '0);
      f.negative = r[W-1];
      f.overflow = (op == ALU_OP_ADD) && (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      return f;
   endfunction

   // Stand-in ALU: purely combinational from the arbiter's operand outputs
   always_comb begin
      alu_out      = alu_ref(alu_opcode, alu_in_a, alu_in_b, alu_input_carry);
      alu_out_flag = flag_ref(alu_opcode, alu_in_a, alu_in_b, alu_input_carry);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic scramble();
      for (int i = 0; i < 2; i++) begin
         req_a[i]      = W'($urandom);
         req_b[i]      = W'($urandom);
         req_opcode[i] = enum_alu_opcode_t'(3'($urandom_range(0, 7)));
         req_mode[i]   = 1'($urandom_range(0, 1));
         req_carry[i]  = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic load(input int id, input enum_alu_opcode_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic mode, input logic c);
      req_opcode[id] = op;
      req_a[id]      = a;
      req_b[id]      = b;
      req_mode[id]   = mode;
      req_carry[id]  = c;
   endtask

   // One full transaction from an IDLE negedge to the IDLE negedge after the handshake.
   // vld: request pattern at accept; vld_during: pattern driven afterwards; hold: cycles
   // rsp_ready stays low once the response is up.
   task automatic txn(input logic [1:0] vld, input logic [1:0] vld_during, input int hold);
      int               g;
      int               lat;
      int               exp_lat;
      logic [W-1:0]     ea;
      logic [W-1:0]     eb;
      enum_alu_opcode_t eop;
      logic             emode;
      logic [W-1:0]     ed;
      struct_alu_flag_t ef;
      g       = (vld == 2'b11) ? (mdl_last ? 0 : 1) : (vld[1] ? 1 : 0);
      ea      = req_a[g];
      eb      = req_b[g];
      eop     = req_opcode[g];
      emode   = req_mode[g];
      ed      = alu_ref(eop, ea, eb, req_carry[g]);
      ef      = flag_ref(eop, ea, eb, req_carry[g]);
      exp_lat = (((eop == ALU_OP_MUL) || (eop == ALU_OP_DIV)) && !emode) ? MC + 1 : 2;
      req_valid = vld;
      #1;
      chk("ready_at_accept", 64'(req_ready), 64'(2'b01 << g));
      chk("idle_not_busy", 64'(busy), 64'(0));
      step();
      req_valid = vld_during;
      scramble();
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         chk("busy_exec", 64'(busy), 64'(1));
         chk("ready_exec", 64'(req_ready), 64'(0));
         chk("alu_a_exec", 64'(alu_in_a), 64'(ea));
         step();
         lat++;
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("rsp_id", 64'(rsp_id), 64'(g));
      chk("rsp_data", 64'(rsp_data), 64'(ed));
      chk("rsp_flag", 64'(rsp_flag), 64'(ef));
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_valid", 64'(rsp_valid), 64'(1));
         chk("hold_data", 64'(rsp_data), 64'(ed));
         chk("hold_flag", 64'(rsp_flag), 64'(ef));
         chk("hold_id", 64'(rsp_id), 64'(g));
         chk("hold_alu_b", 64'(alu_in_b), 64'(eb));
         chk("hold_alu_op", 64'(alu_opcode), 64'(eop));
         chk("ready_resp", 64'(req_ready), 64'(0));
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_dropped", 64'(rsp_valid), 64'(0));
      chk("back_idle", 64'(busy), 64'(0));
      mdl_last = g[0];
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b00;
      rsp_ready  = 1'b0;
      req_a      = '0;
      req_b      = '0;
      req_opcode = '0;
      req_mode   = '0;
      req_carry  = '0;
      mdl_last   = 1'b1;
      step();
      step();
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_alu_a", 64'(alu_in_a), 64'(0));
      chk("rst_alu_op", 64'(alu_opcode), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      rst_n = 1'b1;
      step();

      // Req0 ADD 3+5
      load(0, ALU_OP_ADD, 16'd3, 16'd5, 1'b0, 1'b0);
      txn(2'b01, 2'b00, 0);

      // MUL 2*2, multi-cycle
      load(0, ALU_OP_MUL, 16'd2, 16'd2, 1'b0, 1'b0);
      txn(2'b01, 2'b00, 0);

      // CPR mode 1, response stalled 3 cycles
      load(1, ALU_OP_CPR, 16'd20, 16'd10, 1'b1, 1'b0);
      txn(2'b10, 2'b00, 3);

      // Req1 arrives during req0's EXEC and is granted on the first IDLE cycle
      load(0, ALU_OP_SUB, 16'd9, 16'd4, 1'b0, 1'b0);
      load(1, ALU_OP_XOR, 16'h00f0, 16'h0ff0, 1'b0, 1'b0);
      txn(2'b01, 2'b10, 0);
      txn(2'b10, 2'b00, 0);

      // DIV interrupted by reset mid-EXEC
      load(0, ALU_OP_DIV, 16'd10, 16'd2, 1'b0, 1'b0);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      rst_n = 1'b0;
      #1;
      chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_alu_a", 64'(alu_in_a), 64'(0));
      chk("abort_alu_b", 64'(alu_in_b), 64'(0));
      chk("abort_alu_ctl", 64'({alu_mode, alu_input_carry, alu_opcode}), 64'(0));
      chk("abort_rsp", 64'({rsp_id, rsp_flag, rsp_data}), 64'(0));
      step();
      rst_n    = 1'b1;
      mdl_last = 1'b1;
      for (int i = 0; i < MC + 3; i++) begin
         step();
         chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
      end

      // Tie after reset: requester 0 first, then 1, requests held throughout
      load(0, ALU_OP_AND, 16'hff0f, 16'h0ff0, 1'b0, 1'b0);
      load(1, ALU_OP_ADD, 16'hffff, 16'h0001, 1'b0, 1'b1);
      txn(2'b11, 2'b11, 0);
      load(1, ALU_OP_ADD, 16'hffff, 16'h0001, 1'b0, 1'b1);
      txn(2'b11, 2'b00, 1);

      // Randomized traffic
      for (int n = 0; n < 30; n++) begin
         scramble();
         txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
